// File: rtl/map_pkg.sv
// Shared tile-map geometry and types for the map writer and the renderer.
package map_pkg;

    localparam int MAP_WIDTH  = 160;
    localparam int MAP_HEIGHT = 90;
    localparam int TILE_BITS  = 4;
    localparam int MAP_DEPTH  = MAP_WIDTH * MAP_HEIGHT;
    localparam int MAP_AW     = $clog2(MAP_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        FINISH
    } writer_state_t;

    typedef logic [TILE_BITS-1:0] tile_t;

endpackage

// File: rtl/map_tile_writer_if.sv
// Stream, edit and RAM-write-port bundle of the tile map writer.
interface map_tile_writer_if #(
    parameter int TILE_BITS = map_pkg::TILE_BITS,
    parameter int AW        = map_pkg::MAP_AW
);
    logic                 start_in;
    logic [7:0]           byte_in;
    logic                 byte_valid_in;
    logic                 byte_ready_out;
    logic                 edit_valid_in;
    logic [7:0]           edit_x_in;
    logic [6:0]           edit_y_in;
    logic [TILE_BITS-1:0] edit_tile_in;
    logic                 edit_ready_out;
    logic                 we_out;
    logic [AW-1:0]        addr_out;
    logic [TILE_BITS-1:0] data_out;
    logic                 busy_out;
    logic                 done_out;
    logic                 edit_err_out;
    logic [TILE_BITS-1:0] checksum_out;

    modport slave (
        input  start_in, byte_in, byte_valid_in,
        input  edit_valid_in, edit_x_in, edit_y_in, edit_tile_in,
        output byte_ready_out, edit_ready_out,
        output we_out, addr_out, data_out,
        output busy_out, done_out, edit_err_out, checksum_out
    );

    modport master (
        output start_in, byte_in, byte_valid_in,
        output edit_valid_in, edit_x_in, edit_y_in, edit_tile_in,
        input  byte_ready_out, edit_ready_out,
        input  we_out, addr_out, data_out,
        input  busy_out, done_out, edit_err_out, checksum_out
    );

endinterface

// File: rtl/map_tile_writer_addr_calc.sv
// (x,y) to linear tile address with range flag.
// Latency: combinational.
// Backpressure: none.
module map_addr_calc #(
    parameter int WIDTH  = map_pkg::MAP_WIDTH,
    parameter int HEIGHT = map_pkg::MAP_HEIGHT,
    parameter int AW     = map_pkg::MAP_AW
) (
    input  logic [7:0]    x,
    input  logic [6:0]    y,
    output logic [AW-1:0] addr,
    output logic          in_range
);

    localparam logic [AW-1:0] W_AW = AW'(WIDTH);

    // Range is judged on the untruncated coordinates; the address may alias when out of range.
    always_comb begin
        in_range = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
        addr     = AW'(y) * W_AW + AW'(x);
    end

endmodule

// File: rtl/map_tile_writer.sv
// Fills the tile map RAM from a packed byte stream and applies single-tile edits.
// Latency: write port registered, one cycle after the accepting edge (high nibble one cycle later).
// Backpressure: byte_ready_out high only in LOAD_LO (1 byte / 2 cycles); edits accepted only in IDLE.
module map_tile_writer #(
    parameter int WIDTH     = map_pkg::MAP_WIDTH,
    parameter int HEIGHT    = map_pkg::MAP_HEIGHT,
    parameter int TILE_BITS = map_pkg::TILE_BITS
) (
    input  logic         pixel_clk_in,
    input  logic         rst_in,
    map_tile_writer_if.slave bus
);
    import map_pkg::*;

    localparam int            DEPTH     = WIDTH * HEIGHT;
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    writer_state_t        state;
    logic [AW-1:0]        ptr;
    logic [TILE_BITS-1:0] hi_q;
    logic [AW-1:0]        edit_addr;
    logic                 edit_in_range;
    logic                 edit_acc;
    logic                 byte_acc;
    logic [TILE_BITS-1:0] lo_nib;
    logic [TILE_BITS-1:0] hi_nib;

    map_addr_calc #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .AW     (AW)
    ) u_addr_calc (
        .x        (bus.edit_x_in),
        .y        (bus.edit_y_in),
        .addr     (edit_addr),
        .in_range (edit_in_range)
    );

    assign bus.edit_ready_out = (state == IDLE) && !bus.start_in;
    assign edit_acc = bus.edit_valid_in && bus.edit_ready_out;
    assign byte_acc = bus.byte_valid_in && bus.byte_ready_out && (state == LOAD_LO);
    assign lo_nib   = bus.byte_in[TILE_BITS-1:0];
    assign hi_nib   = bus.byte_in[2*TILE_BITS-1:TILE_BITS];

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state              <= IDLE;
            ptr                <= '0;
            hi_q               <= '0;
            bus.we_out         <= 1'b0;
            bus.addr_out       <= '0;
            bus.data_out       <= '0;
            bus.byte_ready_out <= 1'b0;
            bus.busy_out       <= 1'b0;
            bus.done_out       <= 1'b0;
            bus.edit_err_out   <= 1'b0;
            bus.checksum_out   <= '0;
        end else begin
            bus.we_out   <= 1'b0;
            bus.done_out <= 1'b0;
            // A start pulse (re)starts from address 0 and drops any pending high nibble.
            if (bus.start_in) begin
                state              <= LOAD_LO;
                ptr                <= '0;
                bus.checksum_out   <= '0;
                bus.busy_out       <= 1'b1;
                bus.edit_err_out   <= 1'b0;
                bus.byte_ready_out <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (edit_acc) begin
                            if (edit_in_range) begin
                                bus.we_out   <= 1'b1;
                                bus.addr_out <= edit_addr;
                                bus.data_out <= bus.edit_tile_in;
                            end else begin
                                bus.edit_err_out <= 1'b1;
                            end
                        end
                    end
                    LOAD_LO: begin
                        if (byte_acc) begin
                            bus.we_out         <= 1'b1;
                            bus.addr_out       <= ptr;
                            bus.data_out       <= lo_nib;
                            bus.checksum_out   <= bus.checksum_out ^ lo_nib;
                            hi_q               <= hi_nib;
                            bus.byte_ready_out <= 1'b0;
                            state              <= LOAD_HI;
                        end
                    end
                    LOAD_HI: begin
                        bus.we_out       <= 1'b1;
                        bus.addr_out     <= ptr + AW'(1);
                        bus.data_out     <= hi_q;
                        bus.checksum_out <= bus.checksum_out ^ hi_q;
                        if (ptr + AW'(1) == LAST_ADDR) begin
                            ptr   <= '0;
                            state <= FINISH;
                        end else begin
                            ptr                <= ptr + AW'(2);
                            bus.byte_ready_out <= 1'b1;
                            state              <= LOAD_LO;
                        end
                    end
                    FINISH: begin
                        bus.done_out <= 1'b1;
                        bus.busy_out <= 1'b0;
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_map_tile_writer.sv
// Self-checking bench for map_tile_writer: edit vector table plus load/abort/reset sequences.
module tb_map_tile_writer;
    import map_pkg::*;

    localparam int DEPTH = MAP_DEPTH;

    typedef struct {
        logic [13:0] addr;
        tile_t       data;
    } wr_t;

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        tile_t       tile;
        bit          exp_we;
        int          exp_addr;
        bit          exp_err;
    } edit_vec_t;

    logic clk;
    logic rst_n;

    map_tile_writer_if #(.TILE_BITS(4), .AW(14)) bus ();

    map_tile_writer dut (
        .pixel_clk_in (clk),
        .rst_in       (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t sb_q[$];
    int  exp_ptr = 0;
    tile_t exp_ck = '0;

    int cyc = 0;
    int wcount = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int done_cnt = 0;
    int done_cyc = -1;
    int prev_busy = 0;
    wr_t e;

    edit_vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input int a, input tile_t d);
        wr_t w;
        w.addr = a[13:0];
        w.data = d;
        sb_q.push_back(w);
    endtask

    // Write-port monitor: every write must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (bus.we_out) begin
                wcount++;
                if (first_cyc < 0) first_cyc = cyc;
                if (bus.addr_out == 14'(DEPTH - 1)) last_cyc = cyc;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected_we: got write addr=%0d data=%0d, required no write",
                             bus.addr_out, bus.data_out);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_addr", int'(bus.addr_out), int'(e.addr));
                    chk("wr_data", int'(bus.data_out), int'(e.data));
                end
            end
            if (bus.done_out) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", int'(bus.busy_out), 0);
                chk("busy_before_done", prev_busy, 1);
            end
            prev_busy = int'(bus.busy_out);
        end
    end

    task automatic start_load();
        bus.byte_valid_in = 1'b0;
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        exp_ptr = 0;
        exp_ck = '0;
    endtask

    // Offers one byte after 'gap' idle cycles; with abort_hi, restarts the load while its high nibble is pending.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit abort_hi);
        bit hs;
        hs = 1'b0;
        if (gap > 0) begin
            bus.byte_valid_in = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        bus.byte_in = b;
        bus.byte_valid_in = 1'b1;
        for (int t = 0; t < 40 && !hs; t++) begin
            @(negedge clk); #1;
            if (bus.byte_ready_out) begin
                hs = 1'b1;
                push_wr(exp_ptr, b[3:0]);
                exp_ck ^= b[3:0];
                if (!abort_hi) begin
                    push_wr(exp_ptr + 1, b[7:4]);
                    exp_ck ^= b[7:4];
                    exp_ptr += 2;
                end
            end
            @(posedge clk); #1;
        end
        if (!hs) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_timeout: got no ready within 40 cycles, required handshake");
        end
        if (abort_hi) begin
            bus.byte_valid_in = 1'b0;
            bus.start_in = 1'b1;
            exp_ptr = 0;
            exp_ck = '0;
            @(posedge clk); #1;
            bus.start_in = 1'b0;
        end
    endtask

    task automatic wait_done(input int target);
        for (int t = 0; t < 20 && done_cnt < target; t++) @(negedge clk);
        #1;
        chk("done_count", done_cnt, target);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish by %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{x:8'd0,   y:7'd0,   tile:4'd3,  exp_we:1'b1, exp_addr:0,     exp_err:1'b0};
        vecs[1] = '{x:8'd159, y:7'd89,  tile:4'd7,  exp_we:1'b1, exp_addr:14399, exp_err:1'b0};
        vecs[2] = '{x:8'd5,   y:7'd2,   tile:4'd9,  exp_we:1'b1, exp_addr:325,   exp_err:1'b0};
        vecs[3] = '{x:8'd159, y:7'd0,   tile:4'd1,  exp_we:1'b1, exp_addr:159,   exp_err:1'b0};
        vecs[4] = '{x:8'd0,   y:7'd89,  tile:4'd4,  exp_we:1'b1, exp_addr:14240, exp_err:1'b0};
        vecs[5] = '{x:8'd160, y:7'd0,   tile:4'd2,  exp_we:1'b0, exp_addr:0,     exp_err:1'b1};
        vecs[6] = '{x:8'd0,   y:7'd90,  tile:4'd6,  exp_we:1'b0, exp_addr:0,     exp_err:1'b1};
        vecs[7] = '{x:8'd255, y:7'd127, tile:4'd8,  exp_we:1'b0, exp_addr:0,     exp_err:1'b1};
        vecs[8] = '{x:8'd7,   y:7'd1,   tile:4'd15, exp_we:1'b1, exp_addr:167,   exp_err:1'b1};

        rst_n = 1'b0;
        bus.start_in = 1'b0;
        bus.byte_in = '0;
        bus.byte_valid_in = 1'b0;
        bus.edit_valid_in = 1'b0;
        bus.edit_x_in = '0;
        bus.edit_y_in = '0;
        bus.edit_tile_in = '0;

        // Reset state
        #12;
        chk("rst_we", int'(bus.we_out), 0);
        chk("rst_addr", int'(bus.addr_out), 0);
        chk("rst_data", int'(bus.data_out), 0);
        chk("rst_ready", int'(bus.byte_ready_out), 0);
        chk("rst_busy", int'(bus.busy_out), 0);
        chk("rst_done", int'(bus.done_out), 0);
        chk("rst_err", int'(bus.edit_err_out), 0);
        chk("rst_ck", int'(bus.checksum_out), 0);
        chk("rst_edit_ready", int'(bus.edit_ready_out), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Edit vector table
        for (int i = 0; i < 9; i++) begin
            bus.edit_x_in = vecs[i].x;
            bus.edit_y_in = vecs[i].y;
            bus.edit_tile_in = vecs[i].tile;
            bus.edit_valid_in = 1'b1;
            @(negedge clk); #1;
            chk("edit_ready", int'(bus.edit_ready_out), 1);
            if (vecs[i].exp_we) push_wr(vecs[i].exp_addr, vecs[i].tile);
            @(posedge clk); #1;
            bus.edit_valid_in = 1'b0;
            @(negedge clk); #1;
            chk("edit_err", int'(bus.edit_err_out), int'(vecs[i].exp_err));
            chk("edit_ck", int'(bus.checksum_out), 0);
            @(posedge clk); #1;
        end
        chk("edit_sb_drain", sb_q.size(), 0);

        // Start and edit in the same IDLE cycle: start wins
        bus.edit_x_in = 8'd3;
        bus.edit_y_in = 7'd0;
        bus.edit_tile_in = 4'd5;
        bus.edit_valid_in = 1'b1;
        bus.start_in = 1'b1;
        @(negedge clk); #1;
        chk("conflict_edit_ready", int'(bus.edit_ready_out), 0);
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        bus.edit_valid_in = 1'b0;
        exp_ptr = 0;
        exp_ck = '0;
        first_cyc = -1;
        last_cyc = -1;
        wcount = 0;
        @(negedge clk); #1;
        chk("conflict_busy", int'(bus.busy_out), 1);
        chk("conflict_ready", int'(bus.byte_ready_out), 1);
        chk("start_clears_err", int'(bus.edit_err_out), 0);
        @(posedge clk); #1;

        // Full load, valid held high
        for (int i = 0; i < DEPTH / 2; i++) send_byte(8'h21, 0, 1'b0);
        bus.byte_valid_in = 1'b1;
        wait_done(1);
        chk("full_done_after_last", done_cyc - last_cyc, 1);
        chk("full_write_count", wcount, DEPTH);
        chk("full_no_gaps", last_cyc - first_cyc + 1, DEPTH);
        chk("full_checksum", int'(bus.checksum_out), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("extra_byte_ready", int'(bus.byte_ready_out), 0);
        end
        chk("full_done_once", done_cnt, 1);
        chk("full_sb_drain", sb_q.size(), 0);
        bus.byte_valid_in = 1'b0;
        @(posedge clk); #1;

        // Backpressure with random gaps, then abort while a high nibble is pending
        start_load();
        for (int i = 0; i < 100; i++) begin
            logic [7:0] b;
            b = (i == 3) ? 8'h5A : 8'(8'h10 + i);
            send_byte(b, $urandom_range(0, 2), i == 99);
        end
        @(negedge clk); #1;
        chk("abort_checksum", int'(bus.checksum_out), 0);
        chk("abort_busy", int'(bus.busy_out), 1);
        chk("abort_ready", int'(bus.byte_ready_out), 1);
        chk("abort_no_done", done_cnt, 1);
        chk("abort_sb_drain", sb_q.size(), 0);
        @(posedge clk); #1;

        // Second full load after the abort, random data and gaps
        last_cyc = -1;
        for (int i = 0; i < DEPTH / 2; i++) begin
            if (i == DEPTH / 2 - 1) chk("no_early_done", done_cnt, 1);
            send_byte(8'($urandom), $urandom_range(0, 1), 1'b0);
        end
        bus.byte_valid_in = 1'b0;
        wait_done(2);
        chk("load2_done_after_last", done_cyc - last_cyc, 1);
        chk("load2_checksum", int'(bus.checksum_out), int'(exp_ck));
        chk("load2_sb_drain", sb_q.size(), 0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a load
        start_load();
        for (int i = 0; i < 50; i++) send_byte(8'(i * 7 + 3), 0, 1'b0);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("mid_rst_we", int'(bus.we_out), 0);
        chk("mid_rst_addr", int'(bus.addr_out), 0);
        chk("mid_rst_data", int'(bus.data_out), 0);
        chk("mid_rst_ready", int'(bus.byte_ready_out), 0);
        chk("mid_rst_busy", int'(bus.busy_out), 0);
        chk("mid_rst_ck", int'(bus.checksum_out), 0);
        chk("mid_rst_done", int'(bus.done_out), 0);
        chk("mid_rst_edit_ready", int'(bus.edit_ready_out), 1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("post_rst_ready", int'(bus.byte_ready_out), 0);
        end
        chk("post_rst_busy", int'(bus.busy_out), 0);
        chk("post_rst_done_total", done_cnt, 2);
        bus.byte_valid_in = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
